// File: rtl/iwanna_soc_hpi_bridge.sv
// Avalon-MM slave that turns one read/write into one timed CY7C67200 HPI cycle.
// Setup/strobe/hold lengths are parameters; the master is stalled until DONE.
module iwanna_soc_hpi_bridge #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  otg_addr,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       is_wr;
  logic       request, wr_sel, busy_nxt, capture;

  assign request     = chipselect & (~read_n | ~write_n);
  assign waitrequest = request & (state != DONE);

  // Direction for the pin registers: live input when launching, latched otherwise.
  assign wr_sel   = (state == IDLE) ? ~write_n : is_wr;
  assign busy_nxt = (state_nxt == SETUP) | (state_nxt == STROBE) | (state_nxt == HOLD);
  assign capture  = (state == STROBE) & (cnt == 4'd0) & ~is_wr;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt - 4'd1;
    case (state)
      IDLE: begin
        cnt_nxt = cnt;
        if (request) begin
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LD;
        end
      end
      SETUP: if (cnt == 4'd0) begin
        state_nxt = STROBE;
        cnt_nxt   = STROBE_LD;
      end
      STROBE: if (cnt == 4'd0) begin
        state_nxt = HOLD;
        cnt_nxt   = HOLD_LD;
      end
      HOLD: if (cnt == 4'd0) begin
        state_nxt = DONE;
        cnt_nxt   = 4'd0;
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Pin registers are loaded from the next state so strobes change exactly on state edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      is_wr        <= 1'b0;
      readdata     <= 16'h0000;
      otg_addr     <= 2'd0;
      otg_data_out <= 16'h0000;
      otg_data_oe  <= 1'b0;
      otg_cs_n     <= 1'b1;
      otg_rd_n     <= 1'b1;
      otg_wr_n     <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && request) begin
        is_wr        <= ~write_n;
        otg_addr     <= address;
        otg_data_out <= writedata;
      end
      if (capture) readdata <= otg_data_in;
      otg_cs_n    <= ~busy_nxt;
      otg_data_oe <= busy_nxt & wr_sel;
      otg_rd_n    <= ~((state_nxt == STROBE) & ~wr_sel);
      otg_wr_n    <= ~((state_nxt == STROBE) & wr_sel);
    end
  end

endmodule

// File: doc/iwanna_soc_hpi_bridge.md
# iwanna_soc_hpi_bridge

Avalon-MM slave to Cypress CY7C67200 Host Port Interface (HPI) bus sequencer. Sits directly downstream of the Nios II PIO/Avalon fabric and replaces per-pin software bit-banging of the OTG address, data and strobe pins. Converts one Avalon read or write into one fully timed HPI cycle with programmable setup, strobe and hold, stalling the master with `waitrequest` until the cycle completes.

## Interface
- `SETUP_CYCLES`, default 2: cycles with `otg_cs_n` low, address/data valid, strobe inactive; legal range 1..15.
- `STROBE_CYCLES`, default 4: cycles with `otg_rd_n`/`otg_wr_n` low; legal range 1..15.
- `HOLD_CYCLES`, default 2: cycles after strobe release with `otg_cs_n` low and address/data held; legal range 1..15.
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  HPI register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS; driven onto `otg_addr`.
- `chipselect`  in  1  Avalon slave select.
- `read_n`  in  1  active-low read request.
- `write_n`  in  1  active-low write request.
- `writedata`  in  16  write data.
- `readdata`  out  16  registered read data.
- `waitrequest`  out  1  Avalon stall.
- `otg_addr`  out  2  HPI address pins.
- `otg_data_out`  out  16  HPI data, driven toward the chip.
- `otg_data_oe`  out  1  tristate enable for `otg_data_out`; top-level pad logic drives the bus when high.
- `otg_data_in`  in  16  HPI data pins read back.
- `otg_cs_n`, `otg_rd_n`, `otg_wr_n`  out  1 each  HPI strobes, active low.

## Operation
- Request = `chipselect & (~read_n | ~write_n)`. If both read and write are asserted, the request is a write.
- `waitrequest` is combinational: `request & (state != DONE)`. It is low in IDLE when there is no request.
- States, with transitions evaluated on every rising edge:
  - IDLE: all strobes high, `otg_data_oe` low. On a request, latch `address`, `writedata` and direction, load the counter with `SETUP_CYCLES-1`, and go to SETUP.
  - SETUP: `otg_cs_n` low, `otg_addr` = latched address. `otg_data_oe` is high for a write. When the counter reaches 0, load `STROBE_CYCLES-1` and go to STROBE.
  - STROBE: as SETUP, plus `otg_rd_n` (read) or `otg_wr_n` (write) low. On the final STROBE edge, a read captures `otg_data_in` into `readdata`. When the counter reaches 0, load `HOLD_CYCLES-1` and go to HOLD.
  - HOLD: strobe high; `otg_cs_n`, address and write data/`oe` unchanged. When the counter reaches 0, go to DONE.
  - DONE: one cycle. Strobes high, `oe` low, `waitrequest` low. Always go to IDLE next.
- The counter is 4 bits and decrements each cycle.
- Once the sequencer leaves IDLE, the HPI cycle runs to completion even if `chipselect` drops. It still passes through DONE and the completion is simply unconsumed. Latched values are used, so input changes mid-cycle have no effect on the HPI pins.
- `readdata` holds its value until the next read capture. Writes never alter it.
- Reset values: state IDLE, `readdata` 0, `otg_addr` 0, `otg_data_out` 0, `otg_data_oe` 0, `otg_cs_n`/`otg_rd_n`/`otg_wr_n` 1, `waitrequest` 0 (no request possible during reset).
- Reset asserted mid-cycle aborts immediately and asynchronously: strobes go high and `oe` goes low in the same instant, with no DONE.

## Timing
- A request is first seen in cycle 0 (IDLE). With defaults:
  - SETUP: cycles 1–2.
  - STROBE: cycles 3–6.
  - HOLD: cycles 7–8.
  - DONE: cycle 9.
  - IDLE: cycle 10.
- `waitrequest` is high in cycles 0–8 and low in cycle 9. Avalon completion occurs in cycle 9.
- General busy span: `SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES + 1` cycles including cycle 0.
- Read data is sampled at the edge ending the last STROBE cycle and is valid on `readdata` from HOLD onward, including DONE.
- Back-to-back requests get a mandatory IDLE cycle between DONE and the next SETUP. This gives at least 2 cycles of `otg_cs_n` high between HPI cycles: DONE plus IDLE.
- All HPI outputs are registered, so there are no glitches on the strobes.

## Test plan
- **Write, defaults:** write address=2, writedata=16'h1234 → `otg_cs_n` low in cycles 1–8; `otg_wr_n` low exactly in cycles 3–6; `otg_addr`=2 and `otg_data_out`=16'h1234 with `oe` high in cycles 1–8; `waitrequest` low only in cycle 9; `otg_rd_n` stays high.
- **Read, defaults:** read address=0 with `otg_data_in`=16'hBEEF during STROBE, changed to 16'h0000 in HOLD → `otg_rd_n` low in cycles 3–6; `readdata`=16'hBEEF in cycle 9; `oe` never high.
- **Back-to-back:** write then read with request held continuously → second `otg_cs_n` falling edge exactly 2 cycles after the first cycle's HOLD ends; second `waitrequest` low in cycle 19.
- **Simultaneous read and write:** `read_n`=`write_n`=0 → write cycle performed; `readdata` unchanged from its prior value.
- **Abandoned request:** drop `chipselect` in cycle 4 of a write → `otg_wr_n` still low in cycles 3–6, DONE reached in cycle 9, IDLE in cycle 10; a new request in cycle 10 starts normally.
- **Reset mid-strobe:** assert `reset_n`=0 in cycle 5 of a read → `otg_cs_n`=`otg_rd_n`=1, `oe`=0 and `readdata`=0 immediately; after release the state is IDLE and a fresh read completes with `SETUP_CYCLES`=1, `STROBE_CYCLES`=1, `HOLD_CYCLES`=1 (`waitrequest` low in cycle 4).
